// File: rtl/tsp_disp_pkg.sv
// Shared definitions for the best-tour-cost seven-segment display: state
// encoding, segment codes, BCD sizing and the double-dabble adjust step.
package tsp_disp_pkg;

    localparam int DIGITS = 6;
    localparam int BCD_W  = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        LATCH
    } state_t;

    // Segment drives are active-low, bit6..0 = g..a.
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;

    // Double-dabble correction: any digit >= 5 gets +3 before the next shift.
    function automatic logic [BCD_W-1:0] bcd_add3(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] r;
        r = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

endpackage

// File: rtl/tsp_seg7_dec.sv
// Combinational BCD digit to active-low seven-segment decoder; 10-15 blank.
module tsp_seg7_dec
    import tsp_disp_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        // NOTE: default first so every path assigns seg and no latch is inferred.
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/tsp_hex_display.sv
// Shows the solver's best-tour cost on HEX5..HEX0 via sequential binary-to-BCD.
// Define TSP_HEX_LZB_EN to blank leading zeros above HEX0.
module tsp_hex_display
    import tsp_disp_pkg::*;
#(
    parameter int VAL_W   = 20,
    parameter int SAT_MAX = 999999
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             val_valid,
    input  logic [VAL_W-1:0] val_data,
    output logic             val_ready,
    output logic             busy,
    output logic             ovf,
    output logic [6:0]       HEX0,
    output logic [6:0]       HEX1,
    output logic [6:0]       HEX2,
    output logic [6:0]       HEX3,
    output logic [6:0]       HEX4,
    output logic [6:0]       HEX5
);

    localparam int               CNT_W    = $clog2(VAL_W);
    localparam logic [VAL_W-1:0] SAT_V    = VAL_W'(SAT_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VAL_W - 1);

    state_t                   state;
    logic [VAL_W-1:0]         bin;
    logic [BCD_W-1:0]         bcd;
    logic [CNT_W-1:0]         cnt;
    logic                     ovf_pending;
    logic [BCD_W+VAL_W-1:0]   shifted;
    logic [6:0]               dec_seg  [DIGITS];
    logic [6:0]               disp_seg [DIGITS];

    assign shifted = {bcd_add3(bcd), bin} << 1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dec
        tsp_seg7_dec u_dec (
            .digit (bcd[4*g +: 4]),
            .seg   (dec_seg[g])
        );
    end

`ifdef TSP_HEX_LZB_EN
    logic zero_above;

    always_comb begin
        disp_seg   = dec_seg;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above && (bcd[4*i +: 4] == 4'd0);
            if (zero_above)
                disp_seg[i] = SEG_BLANK;
        end
    end
`else
    always_comb begin
        disp_seg = dec_seg;
    end
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            // NOTE: the datapath is reset as well, so an aborted conversion leaves no stale digits behind.
            state       <= IDLE;
            val_ready   <= 1'b1;
            busy        <= 1'b0;
            ovf         <= 1'b0;
            ovf_pending <= 1'b0;
            bin         <= '0;
            bcd         <= '0;
            cnt         <= '0;
            HEX0        <= SEG_BLANK;
            HEX1        <= SEG_BLANK;
            HEX2        <= SEG_BLANK;
            HEX3        <= SEG_BLANK;
            HEX4        <= SEG_BLANK;
            HEX5        <= SEG_BLANK;
        end else begin
            // NOTE: non-blocking everywhere here so every register sees pre-edge values.
            case (state)
                IDLE: begin
                    if (val_valid && val_ready) begin
                        bin         <= (val_data > SAT_V) ? SAT_V : val_data;
                        ovf_pending <= (val_data > SAT_V);
                        bcd         <= '0;
                        cnt         <= '0;
                        state       <= CONV;
                        val_ready   <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                CONV: begin
                    {bcd, bin} <= shifted;
                    cnt        <= cnt + 1'b1;
                    if (cnt == CNT_LAST)
                        state <= LATCH;
                end
                LATCH: begin
                    HEX0      <= disp_seg[0];
                    HEX1      <= disp_seg[1];
                    HEX2      <= disp_seg[2];
                    HEX3      <= disp_seg[3];
                    HEX4      <= disp_seg[4];
                    HEX5      <= disp_seg[5];
                    ovf       <= ovf_pending;
                    state     <= IDLE;
                    val_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tsp_hex_display.sv
// Randomized self-checking bench for tsp_hex_display against a decimal-arithmetic model.
module tb_tsp_hex_display;

    localparam int VAL_W   = 20;
    localparam int SAT_MAX = 999999;
    localparam int PERIOD  = 10;
    localparam logic [6:0] SEG_LUT [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    localparam logic [41:0] ALL_BLANK = {6{7'h7F}};

    logic             clk;
    logic             nrst;
    logic             val_valid;
    logic [VAL_W-1:0] val_data;
    logic             val_ready;
    logic             busy;
    logic             ovf;
    logic [6:0]       HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

    int          n_cmp;
    int          n_bad;
    logic [41:0] exp_disp;
    logic        exp_ovf;
    longint      t_prev;
    longint      t_now;

    tsp_hex_display #(.VAL_W(VAL_W), .SAT_MAX(SAT_MAX)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .val_valid (val_valid),
        .val_data  (val_data),
        .val_ready (val_ready),
        .busy      (busy),
        .ovf       (ovf),
        .HEX0      (HEX0),
        .HEX1      (HEX1),
        .HEX2      (HEX2),
        .HEX3      (HEX3),
        .HEX4      (HEX4),
        .HEX5      (HEX5)
    );

    initial begin
        clk = 1'b0;
        forever #(PERIOD/2) clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [41:0] hex_now();
        return {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
    endfunction

    // Decimal digits by division, then segment lookup and optional blanking.
    function automatic logic [41:0] model_disp(input int unsigned v);
        int unsigned s;
        int          d [6];
        logic [41:0] r;
        bit          lead;
        s    = (v > SAT_MAX) ? SAT_MAX : v;
        lead = 1'b1;
        for (int i = 0; i < 6; i++) begin
            d[i] = int'(s % 10);
            s    = s / 10;
        end
        for (int i = 5; i >= 0; i--) begin
            if (d[i] != 0) lead = 1'b0;
            r[7*i +: 7] = SEG_LUT[d[i]];
`ifdef TSP_HEX_LZB_EN
            if (lead && i > 0) r[7*i +: 7] = 7'h7F;
`endif
        end
        return r;
    endfunction

    // Called on a falling edge. Presents v, waits for acceptance, watches the
    // whole window, then checks the result. With hold set, next_v stays valid.
    task automatic send(input int unsigned v, input bit hold, input int unsigned next_v,
                        output longint t_acc);
        logic [41:0] prev;
        int          waited;
        int          low;
        int          unstable;
        int          not_busy;
        prev      = exp_disp;
        waited    = 0;
        low       = 0;
        unstable  = 0;
        not_busy  = 0;
        t_acc     = 0;
        val_valid = 1'b1;
        val_data  = v[VAL_W-1:0];
        while (!val_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!val_ready) begin
            check("accept_timeout", 64'(waited), 64'd0);
            val_valid = 1'b0;
            return;
        end
        @(posedge clk);
        t_acc = $time;
        @(negedge clk);
        if (hold) val_data = next_v[VAL_W-1:0];
        else      val_valid = 1'b0;
        for (int k = 0; k < VAL_W + 1; k++) begin
            if (hex_now() !== prev) unstable++;
            if (!val_ready) low++;
            if (!busy) not_busy++;
            @(negedge clk);
        end
        exp_disp = model_disp(v);
        exp_ovf  = (v > SAT_MAX);
        check("hex_stable", 64'(unstable), 64'd0);
        check("busy_window", 64'(not_busy), 64'd0);
        check("ready_low_cycles", 64'(low), 64'(VAL_W + 1));
        check("hex_value", 64'(hex_now()), 64'(exp_disp));
        check("ovf", 64'(ovf), 64'(exp_ovf));
        check("ready_back", 64'(val_ready), 64'd1);
        check("busy_done", 64'(busy), 64'd0);
    endtask

    initial begin
        int unsigned vals [$];
        int unsigned v;
        n_cmp     = 0;
        n_bad     = 0;
        exp_disp  = ALL_BLANK;
        exp_ovf   = 1'b0;
        nrst      = 1'b0;
        val_valid = 1'b0;
        val_data  = '0;

        repeat (2) @(negedge clk);
        check("rst_hex", 64'(hex_now()), 64'(ALL_BLANK));
        check("rst_ready", 64'(val_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        nrst = 1'b1;
        @(negedge clk);

        send(123456, 1'b0, 0, t_now);
        check("hex_123456", 64'(hex_now()),
              64'({7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}));
        send(0, 1'b0, 0, t_now);
        send(1048575, 1'b0, 0, t_now);
        send(999999, 1'b0, 0, t_now);

        // 777 is held valid throughout 42's conversion; it must wait its turn.
        send(42, 1'b1, 777, t_prev);
        send(777, 1'b0, 0, t_now);
        check("held_period", 64'((t_now - t_prev) / PERIOD), 64'(VAL_W + 2));

        // Reset ten cycles into a conversion, with a saturated value on display.
        send(1048575, 1'b0, 0, t_now);
        val_valid = 1'b1;
        val_data  = VAL_W'(555555);
        @(posedge clk);
        @(negedge clk);
        val_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 nrst = 1'b0;
        #1;
        check("abort_hex", 64'(hex_now()), 64'(ALL_BLANK));
        check("abort_ovf", 64'(ovf), 64'd0);
        check("abort_ready", 64'(val_ready), 64'd1);
        check("abort_busy", 64'(busy), 64'd0);
        @(negedge clk);
        nrst = 1'b1;
        repeat (VAL_W + 5) @(negedge clk);
        exp_disp = ALL_BLANK;
        exp_ovf  = 1'b0;
        check("post_abort_hex", 64'(hex_now()), 64'(ALL_BLANK));
        check("post_abort_ready", 64'(val_ready), 64'd1);

        // Random values biased toward small numbers and the saturation edge.
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0:       v = $urandom_range(0, 99);
                1:       v = $urandom_range(SAT_MAX - 3, SAT_MAX + 3);
                default: v = $urandom_range(0, (1 << VAL_W) - 1);
            endcase
            vals.push_back(v);
        end
        for (int i = 0; i < vals.size(); i++) begin
            bit hold;
            hold = (i + 1 < vals.size()) && ($urandom_range(0, 1) == 1);
            send(vals[i], hold, hold ? vals[i+1] : 0, t_now);
            if (i > 0 && val_valid === 1'b0 && t_prev != 0) begin
            end
            if (hold) begin
                t_prev = t_now;
                send(vals[i+1], 1'b0, 0, t_now);
                check("b2b_period", 64'((t_now - t_prev) / PERIOD), 64'(VAL_W + 2));
                i++;
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #(PERIOD * 20000);
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
